// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer.
// Emits start bit, DATA_WIDTH data bits LSB-first, an optional parity bit and a
// stop bit, one bit per rising edge of the TX bit clock. Data and framing
// options are captured when a request is accepted, so changes to the inputs
// cannot disturb a frame that is already on the line. A request that arrives
// during the stop bit starts the next frame with no idle gap.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Parity bit for a data word: XOR of all bits, inverted for odd parity.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic [2:0]            state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [DATA_WIDTH-1:0] data_q,    data_d;
  logic                  par_en_q,  par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_out_q,  tx_out_d;
  logic                  busy_q,    busy_d;

  logic                  accept_s;
  logic [CNT_W-1:0]      cnt_inc_s;

  // Next-state, next-output and capture logic for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_out_d  = tx_out_q;
    busy_d    = busy_q;
    cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    // Requests are only honoured once the line is idle or on its stop bit.
    accept_s  = data_valid && ((state_q == S_IDLE) || (state_q == S_STOP));

    case (state_q)
      S_IDLE, S_STOP: begin
        if (accept_s) begin
          state_d   = S_START;
          data_d    = p_data;
          par_en_d  = par_en;
          par_bit_d = parity_bit(p_data, par_typ);
          cnt_d     = {CNT_W{1'b0}};
          tx_out_d  = 1'b0;
          busy_d    = 1'b1;
        end else begin
          state_d   = S_IDLE;
          cnt_d     = {CNT_W{1'b0}};
          tx_out_d  = 1'b1;
          busy_d    = 1'b0;
        end
      end
      S_START: begin
        state_d  = S_DATA;
        cnt_d    = {CNT_W{1'b0}};
        tx_out_d = data_q[0];
        busy_d   = 1'b1;
      end
      S_DATA: begin
        busy_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          if (par_en_q) begin
            state_d  = S_PARITY;
            tx_out_d = par_bit_q;
          end else begin
            state_d  = S_STOP;
            tx_out_d = 1'b1;
          end
        end else begin
          // The counter tracks the index of the bit currently on the line.
          cnt_d    = cnt_inc_s;
          tx_out_d = data_q[cnt_inc_s];
        end
      end
      S_PARITY: begin
        state_d  = S_STOP;
        tx_out_d = 1'b1;
        busy_d   = 1'b1;
      end
      default: begin
        state_d  = S_IDLE;
        cnt_d    = {CNT_W{1'b0}};
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State, capture and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      data_q    <= {DATA_WIDTH{1'b0}};
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_out = tx_out_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed frames from the test plan plus
// a randomized run compared against a frame-queue reference model.
module tb_uart_tx_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_en;
  logic          par_typ;
  logic          tx_out;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: the bit currently shown and the bits still to come.
  bit m_tx   = 1'b1;
  bit m_busy = 1'b0;
  bit m_rem[$];

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  // Bit clock.
  always #5 clk = ~clk;

  // Model of one rising edge: a new frame may start only when nothing remains queued.
  task automatic model_edge();
    bit frame[$];
    if (!rst) begin
      m_rem.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end else if (m_rem.size() == 0) begin
      if (data_valid) begin
        frame.push_back(1'b0);
        for (int i = 0; i < DW; i++) frame.push_back(p_data[i]);
        if (par_en) frame.push_back(bit'(($countones(p_data) % 2) == (par_typ ? 0 : 1)));
        frame.push_back(1'b1);
        m_tx   = frame.pop_front();
        m_busy = 1'b1;
        m_rem  = frame;
      end else begin
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end
    end else begin
      m_tx   = m_rem.pop_front();
      m_busy = 1'b1;
    end
  endtask

  // Advance one clock edge (model and DUT together), ending at the falling edge.
  task automatic advance();
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; data_valid = 1'b1; p_data = 8'hFF; par_en = 1'b1; par_typ = 1'b0;
    advance();
    advance();
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got tx=%b busy=%b exp tx=1 busy=0", tx_out, busy);
    end
    rst = 1'b1; data_valid = 1'b0;
    for (int i = 0; i < 3; i++) advance();
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got tx=%b busy=%b exp tx=1 busy=0", tx_out, busy);
    end
  endtask

  task automatic test_parity(input logic typ, input logic [10:0] exp_seq);
    logic [10:0] obs;
    int bcnt;
    obs = 11'd0; bcnt = 0;
    p_data = 8'hA5; par_en = 1'b1; par_typ = typ; data_valid = 1'b1;
    advance();
    data_valid = 1'b0; p_data = 8'h00; par_typ = ~typ;
    for (int i = 0; i < 11; i++) begin
      obs = {obs[9:0], tx_out};
      if (busy) bcnt++;
      advance();
    end
    checks++;
    if (obs !== exp_seq) begin
      failures++;
      $display("FAIL parity%0d_seq got=%b exp=%b", typ, obs, exp_seq);
    end
    checks++;
    if (bcnt != 11) begin
      failures++;
      $display("FAIL parity%0d_busy_len got=%0d exp=11", typ, bcnt);
    end
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL parity%0d_end got tx=%b busy=%b exp tx=1 busy=0", typ, tx_out, busy);
    end
  endtask

  task automatic test_no_parity();
    logic [9:0] obs;
    int bcnt;
    obs = 10'd0; bcnt = 0;
    p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
    advance();
    data_valid = 1'b0; par_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      obs = {obs[8:0], tx_out};
      if (busy) bcnt++;
      advance();
    end
    checks++;
    if (obs !== 10'b0001111001) begin
      failures++;
      $display("FAIL nopar_seq got=%b exp=%b", obs, 10'b0001111001);
    end
    checks++;
    if (bcnt != 10 || busy !== 1'b0 || tx_out !== 1'b1) begin
      failures++;
      $display("FAIL nopar_busy got len=%0d end_busy=%b end_tx=%b exp len=10 busy=0 tx=1", bcnt, busy, tx_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] obs;
    int bcnt;
    obs = 20'd0; bcnt = 0;
    p_data = 8'h01; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
    advance();
    data_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      obs = {obs[18:0], tx_out};
      if (busy) bcnt++;
      if (i == 9) begin
        p_data = 8'hFF; data_valid = 1'b1;
      end else begin
        data_valid = 1'b0;
      end
      advance();
    end
    checks++;
    if (obs !== 20'b01000000010111111111) begin
      failures++;
      $display("FAIL b2b_seq got=%b exp=%b", obs, 20'b01000000010111111111);
    end
    checks++;
    if (bcnt != 20) begin
      failures++;
      $display("FAIL b2b_busy_len got=%0d exp=20", bcnt);
    end
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got tx=%b busy=%b exp tx=1 busy=0", tx_out, busy);
    end
  endtask

  task automatic test_ignored_request();
    logic [13:0] obs;
    int bcnt;
    obs = 14'd0; bcnt = 0;
    p_data = 8'h0F; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
    advance();
    data_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      obs = {obs[12:0], tx_out};
      if (busy) bcnt++;
      if (i == 3) begin
        p_data = 8'h55; par_en = 1'b1; data_valid = 1'b1;
      end else begin
        data_valid = 1'b0;
      end
      advance();
    end
    checks++;
    if (obs !== 14'b01111000011111) begin
      failures++;
      $display("FAIL ignored_seq got=%b exp=%b", obs, 14'b01111000011111);
    end
    checks++;
    if (bcnt != 10 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ignored_busy got len=%0d end_busy=%b exp len=10 busy=0", bcnt, busy);
    end
  endtask

  task automatic test_mid_reset();
    logic [10:0] obs;
    obs = 11'd0;
    p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
    advance();
    data_valid = 1'b0;
    for (int i = 0; i < 4; i++) advance();
    rst = 1'b0;
    advance();
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_abort got tx=%b busy=%b exp tx=1 busy=0", tx_out, busy);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) advance();
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_no_resume got tx=%b busy=%b exp tx=1 busy=0", tx_out, busy);
    end
    p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
    advance();
    data_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      obs = {obs[9:0], tx_out};
      advance();
    end
    checks++;
    if (obs !== 11'b01010010101 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_clean_frame got=%b busy=%b exp=%b busy=0", obs, busy, 11'b01010010101);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 79) != 0);
      data_valid = ($urandom_range(0, 3) == 0);
      p_data     = DW'($urandom());
      par_en     = 1'($urandom_range(0, 1));
      par_typ    = 1'($urandom_range(0, 1));
      advance();
      checks++;
      if (tx_out !== m_tx || busy !== m_busy) begin
        failures++;
        if (bad < 10)
          $display("FAIL random_cycle%0d got tx=%b busy=%b exp tx=%b busy=%b", i, tx_out, busy, m_tx, m_busy);
        bad++;
      end
    end
    rst = 1'b1; data_valid = 1'b0;
    for (int i = 0; i < 12; i++) advance();
  endtask

  // Test sequence.
  initial begin
    rst = 1'b0; data_valid = 1'b0; p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0;
    @(negedge clk);
    test_reset();
    test_parity(1'b0, 11'b01010010101);
    test_parity(1'b1, 11'b01010010111);
    test_no_parity();
    test_back_to_back();
    test_ignored_request();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmit path.
- Accepts a parallel byte with a valid strobe and drives the serial line one bit per clk cycle, where clk is the TX bit clock.
- Frame order: start bit, data bits LSB-first, optional parity bit, stop bit.
- Owns the frame FSM, bit counter, data/config capture register and parity generation, so the TX output stage needs no other control.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (supported 5..9)

Ports:
clk  input  1  TX bit clock; all logic on its rising edge
rst  input  1  synchronous active-low reset
p_data  input  DATA_WIDTH  parallel data to transmit
data_valid  input  1  one-cycle request; p_data and config are valid in this cycle
par_en  input  1  1 = frame includes a parity bit
par_typ  input  1  0 = even parity, 1 = odd parity
tx_out  output  1  serial line; idle level 1
busy  output  1  1 while a frame is on the line (START..STOP)

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous, active-low on rst.
- Reset values: state=IDLE, tx_out=1, busy=0, bit counter=0, capture register=0.
- Reset mid-frame: the frame is aborted, and tx_out=1 / busy=0 from the first edge with rst low. There is no resumption.
- Registered outputs: tx_out and busy are registered; there is no combinational path from any input to either output.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Acceptance: data_valid is sampled only when state is IDLE or STOP.
  - At an accepting edge, p_data, par_en and par_typ are captured.
  - At that same edge the state becomes START, with tx_out=0 and busy=1.
  - data_valid in START, DATA or PARITY is ignored. The current frame is unaffected and nothing is queued.
- Parity is computed from the captured data at acceptance: par = XOR of all DATA_WIDTH bits; parity bit = par when par_typ=0, ~par when par_typ=1. Later input changes do not affect the frame in flight.
- START (1 cycle): tx_out=0, then go to DATA with counter=0.
- DATA (DATA_WIDTH cycles):
  - tx_out = captured bit[counter]; counter increments each cycle.
  - On the cycle with counter = DATA_WIDTH-1, go to PARITY if par_en is captured high, otherwise go to STOP.
- PARITY (1 cycle): tx_out = parity bit, then go to STOP.
- STOP (1 cycle): tx_out=1, busy=1.
  - If data_valid=1 in this cycle, the next state is START (back-to-back frames, no idle gap).
  - Otherwise the next state is IDLE with busy=0.
- IDLE: tx_out=1, busy=0.
- Frame length: 1 + DATA_WIDTH + par_en + 1 cycles, i.e. 11 cycles (parity) or 10 cycles (no parity) at DATA_WIDTH=8.
- Counter width is clog2(DATA_WIDTH); the counter never wraps inside a frame.
- Simultaneous events: rst low overrides data_valid. data_valid at an IDLE edge starts the frame at that edge, with no extra latency cycle.

Test Plan:
- Even parity: reset, then p_data=0xA5, par_en=1, par_typ=0, data_valid for 1 cycle.
  -> tx_out sequence 0,1,0,1,0,0,1,0,1,0,1 (parity bit 0), busy high for exactly 11 cycles, then tx_out=1 and busy=0.
- Odd parity: same frame with par_typ=1.
  -> parity cycle tx_out=1; all other bits identical to the even-parity case.
- No parity: p_data=0x3C, par_en=0.
  -> tx_out sequence 0,0,0,1,1,1,1,0,0,1; busy high for 10 cycles; no parity cycle.
- Back-to-back: send 0x01, then assert data_valid with 0xFF during its STOP cycle (par_en=0).
  -> the next cycle is the START of 0xFF; busy stays high for 20 continuous cycles.
- Ignored request: data_valid with 0x55 while in the DATA state of a 0x0F frame.
  -> 0x0F is transmitted unchanged, no second frame follows, and busy falls after STOP.
- Mid-frame reset: assert rst=0 during the DATA state.
  -> at the next edge tx_out=1, busy=0, state IDLE. A new data_valid after reset release starts a clean frame.
